// File: rtl/mdu_pkg.sv
// Shared encodings for the multiply/divide unit: MDOp opcodes, FSM states
// and opcode classification helpers.
// Optional feature macro: MDU_MADD_EN (multiply-accumulate / multiply-subtract).
package mdu_pkg;

  localparam logic [2:0] MD_MULT  = 3'd0;
  localparam logic [2:0] MD_MULTU = 3'd1;
  localparam logic [2:0] MD_DIV   = 3'd2;
  localparam logic [2:0] MD_DIVU  = 3'd3;
  localparam logic [2:0] MD_MTHI  = 3'd4;
  localparam logic [2:0] MD_MTLO  = 3'd5;
  localparam logic [2:0] MD_MADD  = 3'd6;
  localparam logic [2:0] MD_MSUB  = 3'd7;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Opcodes that occupy the unit for a multi-cycle run.
  function automatic logic is_run_op(input logic [2:0] op);
    logic hit;
    hit = (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
`ifdef MDU_MADD_EN
    hit = hit || (op == MD_MADD) || (op == MD_MSUB);
`endif
    return hit;
  endfunction

  // Opcodes that use the divide latency rather than the multiply latency.
  function automatic logic is_div_op(input logic [2:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/mdu_div_core.sv
// Combinational WIDTH-bit signed/unsigned divider.
// Signed mode truncates the quotient toward zero and gives the remainder the
// sign of the dividend. Divide-by-zero returns quotient all-ones and
// remainder = dividend; most-negative / -1 returns most-negative, remainder 0.
import mdu_pkg::*;

module mdu_div_core #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             is_signed,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  logic             neg_a;
  logic             neg_b;
  logic             div_zero;
  logic             overflow;
  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;
  logic [WIDTH-1:0] safe_b;
  logic [WIDTH-1:0] q_mag;
  logic [WIDTH-1:0] r_mag;

  assign neg_a    = is_signed & dividend[WIDTH-1];
  assign neg_b    = is_signed & divisor[WIDTH-1];
  assign div_zero = (divisor == '0);
  assign overflow = is_signed && (dividend == MOST_NEG) && (divisor == '1);

  assign mag_a  = neg_a ? -dividend : dividend;
  assign mag_b  = neg_b ? -divisor  : divisor;
  // Substitute 1 for a zero divisor so the divide operator never sees 0;
  // the real divide-by-zero result is selected below.
  assign safe_b = div_zero ? {{(WIDTH-1){1'b0}}, 1'b1} : mag_b;
  assign q_mag  = mag_a / safe_b;
  assign r_mag  = mag_a % safe_b;

  // Sign fixup of the magnitude result, then the two boundary overrides.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned
    // and a latch can never be inferred.
    quotient  = (neg_a ^ neg_b) ? -q_mag : q_mag;
    remainder = neg_a ? -r_mag : r_mag;
    if (div_zero) begin
      quotient  = '1;
      remainder = dividend;
    end else if (overflow) begin
      quotient  = MOST_NEG;
      remainder = '0;
    end
  end

endmodule

// File: rtl/mdu_seq.sv
// Multi-cycle multiply/divide unit with HI/LO result registers.
// The result is computed combinationally from operands latched at Start and
// committed to HI/LO after MULT_LAT or DIV_LAT busy cycles.
// Optional feature macro: MDU_MADD_EN enables MADD/MSUB accumulation into
// {HI,LO}; without it opcodes 6/7 are no-ops.
import mdu_pkg::*;

module mdu_seq #(
  parameter int WIDTH    = 32,
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             Start,
  input  logic [2:0]       MDOp,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  output logic             Busy,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  localparam int MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
  localparam int CNT_W   = $clog2(MAX_LAT + 1);

  state_t             state_q;
  state_t             state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic [CNT_W-1:0]   cnt_d;
  logic               start_run;
  logic               finish;
  logic               move_hi;
  logic               move_lo;

  logic [2:0]         op_q;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
`ifdef MDU_MADD_EN
  logic [2*WIDTH-1:0] acc_q;
`endif

  logic               mul_signed;
  logic [2*WIDTH-1:0] a_ext;
  logic [2*WIDTH-1:0] b_ext;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quo;
  logic [WIDTH-1:0]   rem;
  logic [2*WIDTH-1:0] result;

  assign Busy = (state_q == ST_RUN);

  // Moves complete in one edge and only while idle; Start during a run is ignored.
  assign move_hi = (state_q == ST_IDLE) && Start && (MDOp == MD_MTHI);
  assign move_lo = (state_q == ST_IDLE) && Start && (MDOp == MD_MTLO);

  // State register and countdown.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // NOTE: sequential state uses non-blocking assignment so every register
      // samples pre-edge values regardless of statement order.
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic: launch a run from IDLE, count down, finish at 1.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    start_run = 1'b0;
    finish    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (Start && is_run_op(MDOp)) begin
          state_d   = ST_RUN;
          start_run = 1'b1;
          cnt_d     = is_div_op(MDOp) ? CNT_W'(DIV_LAT) : CNT_W'(MULT_LAT);
        end
      end
      ST_RUN: begin
        if (cnt_q == CNT_W'(1)) begin
          state_d = ST_IDLE;
          finish  = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Operand capture at the launching edge; held stable for the whole run.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op_q  <= MD_MULT;
      a_q   <= '0;
      b_q   <= '0;
`ifdef MDU_MADD_EN
      acc_q <= '0;
`endif
    end else if (start_run) begin
      op_q  <= MDOp;
      a_q   <= SrcA;
      b_q   <= SrcB;
`ifdef MDU_MADD_EN
      acc_q <= {HI, LO};
`endif
    end
  end

  // Full-width product: sign- or zero-extend both operands to 2*WIDTH and
  // keep the low 2*WIDTH bits, which is exact for both signednesses.
  assign mul_signed = (op_q != MD_MULTU);
  assign a_ext = mul_signed ? {{WIDTH{a_q[WIDTH-1]}}, a_q} : {{WIDTH{1'b0}}, a_q};
  assign b_ext = mul_signed ? {{WIDTH{b_q[WIDTH-1]}}, b_q} : {{WIDTH{1'b0}}, b_q};
  assign prod  = a_ext * b_ext;

  mdu_div_core #(
    .WIDTH(WIDTH)
  ) u_div (
    .dividend  (a_q),
    .divisor   (b_q),
    .is_signed (op_q == MD_DIV),
    .quotient  (quo),
    .remainder (rem)
  );

  // Select the {HI,LO} value committed at the end of the run.
  always_comb begin
    result = prod;
    case (op_q)
      MD_DIV, MD_DIVU: result = {rem, quo};
`ifdef MDU_MADD_EN
      MD_MADD:         result = acc_q + prod;
      MD_MSUB:         result = acc_q - prod;
`endif
      default:         result = prod;
    endcase
  end

  // HI/LO architectural registers: run results and single-cycle moves.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // NOTE: HI/LO are architectural state and must come out of reset at a
      // known value, so they are reset along with the control registers.
      HI <= '0;
      LO <= '0;
    end else if (finish) begin
      {HI, LO} <= result;
    end else if (move_hi) begin
      HI <= SrcA;
    end else if (move_lo) begin
      LO <= SrcA;
    end
  end

endmodule

// File: doc/mdu_seq.md
Name: mdu_seq

Overview:
- Parametrised multi-cycle multiply/divide unit with HI/LO result registers.
- Companion to the single-cycle ALU in the execute stage; handles MIPS mult/multu/div/divu/mthi/mtlo.
- The pipeline stalls on Busy.
- Generalises the ALU in three ways: configurable datapath width, configurable per-operation latency, and internal state that persists across instructions.

Parameters:
- WIDTH, 32: operand, HI and LO width in bits; must be even and >= 4.
- MULT_LAT, 5: cycles Busy stays high for multiply ops; must be >= 1.
- DIV_LAT, 10: cycles Busy stays high for divide ops; must be >= 1.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset; single clock domain
- Start  input  1  one-cycle request; qualified by MDOp
- MDOp  input  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6 MADD, 7 MSUB
- SrcA  input  WIDTH  rs operand / dividend / move source
- SrcB  input  WIDTH  rt operand / divisor
- Busy  output  1  operation in flight
- HI  output  WIDTH  high product / remainder
- LO  output  WIDTH  low product / quotient

Behaviour:
- Reset (reset=0, asynchronous):
  - Busy=0, HI=0, LO=0, countdown=0, latched operands cleared.
  - Any in-flight operation is discarded.
  - Takes effect immediately and is independent of clk.
- States:
  - IDLE, RUN.
  - IDLE -> RUN on a clk edge with Start=1 and MDOp in {0,1,2,3,6,7}. Operands and op latched; counter loaded with MULT_LAT (ops 0,1,6,7) or DIV_LAT (ops 2,3).
  - RUN decrements the counter each edge. When the counter reaches 1, the next edge writes HI/LO and returns to IDLE.
- Timing:
  - Busy is high for exactly LAT cycles, starting the cycle after the Start edge.
  - HI/LO hold their old values throughout RUN.
  - New values are visible in the first cycle Busy=0.
- MTHI/MTLO:
  - With Start=1 in IDLE, HI (or LO) is loaded with SrcA at that edge.
  - Single cycle; Busy stays 0.
- Start while Busy=1 is ignored, for every op including moves. The pipeline never issues one; the bench checks it anyway.
- Arithmetic:
  - MULT: signed WIDTH x WIDTH -> 2*WIDTH; HI = upper half, LO = lower half.
  - MULTU: same, unsigned.
  - DIV: LO = quotient truncated toward zero; HI = remainder carrying the dividend's sign.
  - DIVU: unsigned quotient and remainder.
- Divide boundaries:
  - Divisor 0: LO = all ones, HI = SrcA, for both DIV and DIVU.
  - DIV of most-negative by -1: LO = most-negative, HI = 0.
- Results are computed from the operands latched at Start. Operand changes during RUN have no effect.
- Implementation is free: iterative engine or registered combinational result, provided the latency and values above hold exactly.
- MDOp 6/7 without the optional feature: treated as no-op. No state change, Busy stays 0.

Optional Feature:
- Macro: MDU_MADD_EN
- Defined:
  - MADD: {HI,LO} <= {HI,LO} + signed(SrcA)*signed(SrcB).
  - MSUB: {HI,LO} <= {HI,LO} - signed(SrcA)*signed(SrcB).
  - Accumulation is modulo 2^(2*WIDTH).
  - Latency MULT_LAT.
  - The {HI,LO} used is the value at the Start edge.
- Undefined: opcodes 6/7 are no-ops as stated above. No accumulator adder is synthesised.

Decomposition:
- Package mdu_pkg:
  - MDOp encoding constants: MD_MULT, MD_MULTU, MD_DIV, MD_DIVU, MD_MTHI, MD_MTLO, MD_MADD, MD_MSUB.
  - State encoding constants: ST_IDLE, ST_RUN.
- One sub-module, mdu_div_core: the WIDTH-bit signed/unsigned divider, including the divide-by-zero and overflow fixups.
- Multiplier and control FSM stay in mdu_seq.

Test Plan:
- Reset and idle moves: reset low mid-RUN of DIV -> Busy=0, HI=LO=0 immediately. MTHI SrcA=0x1234 then MTLO SrcA=0x5678 -> HI=0x1234, LO=0x5678 next cycle, Busy never asserted.
- MULT latency: MULT SrcA=0xFFFFFFFF (-1), SrcB=5, MULT_LAT=5 -> Busy high exactly 5 cycles. Old HI/LO held during RUN. Then HI=0xFFFFFFFF, LO=0xFFFFFFFB. MULTU with the same operands -> HI=0x00000004, LO=0xFFFFFFFB.
- Signed division: DIV -7 / 2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF after 10 busy cycles. DIVU 0x80000000 / 3 -> LO=0x2AAAAAAA, HI=2.
- Divide boundaries: DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0. DIVU 42 / 0 -> LO=0xFFFFFFFF, HI=42.
- Ignored requests: DIV issued, then MTLO and MULT with Start=1 during Busy -> both ignored, final values are the DIV result. Operands changed mid-RUN -> result unaffected.
- MDU_MADD_EN defined: HI=0, LO=0xFFFFFFFF, then MADD 1*1 -> HI=1, LO=0. Follow with MSUB 2*3 -> HI=0, LO=0xFFFFFFFA. Undefined: MADD leaves HI/LO unchanged and Busy=0.
